prog_dump_tx: RTL
=================

// Module: prog_dump_tx
// PURPOSE
//  Reverse of the UART program loader: reads a block of 16-bit words from main
//  memory and streams them to the host over the uart_mux byte-transmit port.
//  Frame = header word (word count), N data words, end marker word; each word big-endian.
//  Sits in mcu beside the loader; owns the memory bus only while busy=1.
// PARAMETERS
//  ADDR_W     16        memory byte-address width (matches `ADDR_WIDTH)
//  BASE_ADDR  'h4000    byte address of first word dumped (loader load address)
//  END_MARK   16'h7fff  trailer word, same value that terminates a program upload
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous reset, active-high
//  start        in   1       1-cycle pulse: begin dump (ignored while busy)
//  word_count   in   16      words to dump; sampled in the cycle start=1
//  abort        in   1       level: cut dump short, jump to trailer
//  mem_addr     out  ADDR_W  word-aligned byte address (bit0 always 0)
//  rd_mem       out  1       read strobe, 1 cycle
//  rd_data      in   16      read data, valid the cycle after rd_mem
//  tx_data      out  8       byte to uart_mux
//  wr           out  1       1-cycle write strobe to uart_mux
//  tx_ready     in   1       uart_mux transmitter can accept a byte
//  busy         out  1       dump in progress (mcu muxes memory bus to this block)
//  done         out  1       1-cycle pulse after trailer low byte is accepted
// BEHAVIOUR
//  Reset: state IDLE; mem_addr=0, rd_mem=0, tx_data=0, wr=0, busy=0, done=0;
//   reset mid-dump aborts immediately, no further wr; partial frame is lost.
//  States: IDLE -> HDR -> (RD_REQ -> RD_WAIT -> DATA)* -> TRL -> FIN -> IDLE.
//  IDLE: start=1 -> cnt<=word_count, addr<=BASE_ADDR, word<=word_count, busy<=1, -> HDR.
//  Byte send sub-sequence, used by HDR, DATA and TRL (hi byte, then lo byte):
//   wait tx_ready=1; then drive tx_data=byte, wr=1 for exactly one cycle;
//   next cycle is a guard cycle (tx_ready not sampled) so uart_mux can drop it.
//   Never two wr in consecutive cycles; tx_data held stable during wr cycle.
//  HDR: send word; then cnt==0 -> TRL, else -> RD_REQ.
//  RD_REQ: mem_addr=addr, rd_mem=1 for one cycle -> RD_WAIT.
//  RD_WAIT: word<=rd_data (latency exactly 1 cycle) -> DATA.
//  DATA: send word; addr<=addr+2 (mod 2^ADDR_W, wraps silently); cnt<=cnt-1;
//   cnt becomes 0 -> TRL, else -> RD_REQ.
//  TRL: send END_MARK (hi 'h7f, lo 'hff) -> FIN.  FIN: done=1 one cycle, busy<=0 -> IDLE.
//  abort=1: checked only at word boundaries (entry to RD_REQ); -> TRL instead.
//   a word whose hi byte is sent is always completed (no half words).
//  Data words equal to END_MARK are sent verbatim; host frames by header count.
//  Total bytes per frame = 2*word_count + 4.  Memory reads = min(word_count, words before abort).
//  start while busy: ignored, word_count not resampled. start and abort together in
//   IDLE: dump starts; abort honoured at first word boundary (header + trailer only).
//  rd_mem and wr never asserted outside busy=1; rd_mem only in RD_REQ.
// TESTING
//  1 rst, start, word_count=2, mem[4000]=1234, mem[4002]=ABCD, tx_ready=1 ->
//    bytes 00 02 12 34 AB CD 7F FF, two rd_mem at 4000/4002, then done pulse.
//  2 word_count=0 -> bytes 00 00 7F FF, no rd_mem, done pulse, busy back to 0.
//  3 tx_ready held low 50 cycles between bytes -> no wr while low, byte order
//    unchanged, wr never in consecutive cycles.
//  4 word_count=5, abort=1 during 2nd data word -> 00 05, word0, word1, 7F FF; 2 reads.
//  5 BASE_ADDR='hFFFE, word_count=2 -> reads at FFFE then 0000 (wrap).
//  6 rst mid-data-word -> wr/rd_mem/busy=0 next cycle, IDLE; new start gives clean frame.

Source files
------------

// File: rtl/prog_dump_tx.sv
// prog_dump_tx: streams a block of 16-bit words from main memory to the host
// through the uart_mux byte-transmit port. A frame is a header word (word
// count), the data words, then an end-marker word, each sent high byte first.
module prog_dump_tx #(
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h4000,
    parameter logic [15:0]       END_MARK  = 16'h7fff
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       word_count,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              rd_mem,
    input  logic [15:0]       rd_data,
    output logic [7:0]        tx_data,
    output logic              wr,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD_REQ,
        RD_WAIT,
        DATA,
        TRL,
        FIN
    } state_t;

    // Phases of sending one byte: wait for ready, strobe, then a guard cycle.
    typedef enum logic [1:0] {
        PH_WAIT,
        PH_WR,
        PH_GUARD
    } phase_t;

    state_t            state;
    phase_t            phase;
    logic              lo_byte;
    logic [15:0]       cnt;
    logic [15:0]       word;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [7:0]        cur_byte;

    // Byte currently being sent and the following word address.
    always_comb begin
        cur_byte = lo_byte ? word[7:0] : word[15:8];
        addr_inc = addr + ADDR_W'(2);
    end

    // Frame sequencer with registered memory and uart outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= PH_WAIT;
            lo_byte  <= 1'b0;
            cnt      <= '0;
            word     <= '0;
            addr     <= '0;
            mem_addr <= '0;
            rd_mem   <= 1'b0;
            tx_data  <= '0;
            wr       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= word_count;
                        word    <= word_count;
                        addr    <= BASE_ADDR;
                        busy    <= 1'b1;
                        phase   <= PH_WAIT;
                        lo_byte <= 1'b0;
                        state   <= HDR;
                    end
                end

                HDR, DATA, TRL: begin
                    case (phase)
                        PH_WAIT: begin
                            if (tx_ready) begin
                                tx_data <= cur_byte;
                                wr      <= 1'b1;
                                phase   <= PH_WR;
                            end
                        end
                        PH_WR: begin
                            wr    <= 1'b0;
                            phase <= PH_GUARD;
                        end
                        PH_GUARD: begin
                            phase <= PH_WAIT;
                            if (!lo_byte) begin
                                lo_byte <= 1'b1;
                            end else begin
                                lo_byte <= 1'b0;
                                // Word finished: decide where the frame goes
                                // next. Abort is only honoured here, at a word
                                // boundary, so words are never split.
                                if (state == TRL) begin
                                    done  <= 1'b1;
                                    state <= FIN;
                                end else if ((state == HDR && cnt == 16'd0) ||
                                             (state == DATA && cnt == 16'd1) ||
                                             abort) begin
                                    word  <= END_MARK;
                                    state <= TRL;
                                end else begin
                                    mem_addr <= (state == DATA) ? addr_inc : addr;
                                    rd_mem   <= 1'b1;
                                    state    <= RD_REQ;
                                end
                                if (state == DATA) begin
                                    addr <= addr_inc;
                                    cnt  <= cnt - 16'd1;
                                end
                            end
                        end
                        default: phase <= PH_WAIT;
                    endcase
                end

                RD_REQ: begin
                    rd_mem <= 1'b0;
                    state  <= RD_WAIT;
                end

                RD_WAIT: begin
                    word  <= rd_data;
                    state <= DATA;
                end

                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
